// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, init table and command constants for lcd_ctrl
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        SETUP,
        PULSE,
        HOLD,
        EXEC,
        IDLE
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

    localparam int INIT_LEN = 4;
    localparam logic [7:0] INIT_SEQ [INIT_LEN] = '{
        CMD_FUNC_8B2L, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY_INC
    };

    // Clear and both home encodings need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_if.sv
// rtl/lcd_if.sv - core-side byte handshake between the LCD output register and lcd_ctrl
interface lcd_if;
    logic       i_valid;
    logic       i_rs;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_busy;

    modport master (output i_valid, i_rs, i_data, input o_ready, o_busy);
    modport slave  (input i_valid, i_rs, i_data, output o_ready, o_busy);
endinterface

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780-style panel driver: power-up wait, init sequence, byte writes
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_SETUP   = 2,
    parameter int T_PULSE   = 25,
    parameter int T_HOLD    = 2,
    parameter int T_EXEC    = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int T_POWERUP = 750000
) (
    input  logic       clk,
    input  logic       reset_n,
    lcd_if.slave       core,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int M0    = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int M1    = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int M2    = (T_CLEAR > T_POWERUP) ? T_CLEAR : T_POWERUP;
    localparam int M3    = (M0 > M1) ? M0 : M1;
    localparam int T_MAX = (M3 > M2) ? M3 : M2;
    localparam int CW    = $clog2(T_MAX) + 1;

    lcd_state_t    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          ready_q;

    assign core.o_ready = ready_q;
    assign core.o_busy  = ~ready_q;
    assign o_lcd_rw     = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PWR_WAIT;
            cnt        <= '0;
            idx        <= '0;
            ready_q    <= 1'b0;
            o_lcd_on   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
        end else begin
            case (state)
                PWR_WAIT: begin
                    // The first cycle after release (panel still off) is wait cycle one.
                    o_lcd_on <= 1'b1;
                    if (!o_lcd_on && T_POWERUP > 1) begin
                        cnt <= CW'(T_POWERUP - 2);
                    end else if (o_lcd_on && cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state      <= SETUP;
                        cnt        <= CW'(T_SETUP - 1);
                        o_lcd_rs   <= 1'b0;
                        o_lcd_data <= INIT_SEQ[0];
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state    <= PULSE;
                        o_lcd_en <= 1'b1;
                        cnt      <= CW'(T_PULSE - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state    <= HOLD;
                        o_lcd_en <= 1'b0;
                        cnt      <= CW'(T_HOLD - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= EXEC;
                        cnt   <= is_long_cmd(o_lcd_rs, o_lcd_data) ? CW'(T_CLEAR - 1)
                                                                   : CW'(T_EXEC - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (idx < 3'(INIT_LEN - 1)) begin
                        idx        <= idx + 3'd1;
                        state      <= SETUP;
                        cnt        <= CW'(T_SETUP - 1);
                        o_lcd_rs   <= 1'b0;
                        o_lcd_data <= INIT_SEQ[idx[1:0] + 2'd1];
                    end else begin
                        // idx parks at INIT_LEN once init is done, so later bytes skip this path.
                        idx     <= 3'(INIT_LEN);
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (core.i_valid) begin
                        ready_q    <= 1'b0;
                        state      <= SETUP;
                        cnt        <= CW'(T_SETUP - 1);
                        o_lcd_rs   <= core.i_rs;
                        o_lcd_data <= core.i_data;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl
module tb_lcd_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;

    lcd_if bus ();

    lcd_ctrl #(
        .T_SETUP(1), .T_PULSE(3), .T_HOLD(1),
        .T_EXEC(5), .T_CLEAR(20), .T_POWERUP(50)
    ) dut (
        .clk(clk), .reset_n(reset_n), .core(bus),
        .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs),
        .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) cyc = 0;
        else cyc = cyc + 1;
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         width;
        int         rise;
        logic       setup_ok;
        logic       stable;
    } pulse_t;

    pulse_t     pq[$];
    pulse_t     cur;
    logic       prev_en = 1'b0;
    logic [8:0] prev_bus = '0;

    // Records every EN pulse: bus value, width, rise cycle, setup and hold stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_en = 1'b0;
        end else begin
            if (lcd_en && !prev_en) begin
                cur.rs       = lcd_rs;
                cur.data     = lcd_data;
                cur.width    = 1;
                cur.rise     = cyc;
                cur.setup_ok = (prev_bus == {lcd_rs, lcd_data});
                cur.stable   = 1'b1;
            end else if (lcd_en) begin
                cur.width = cur.width + 1;
                if ({lcd_rs, lcd_data} != {cur.rs, cur.data}) cur.stable = 1'b0;
            end else if (prev_en) begin
                if ({lcd_rs, lcd_data} != {cur.rs, cur.data}) cur.stable = 1'b0;
                pq.push_back(cur);
            end
            prev_en = lcd_en;
        end
        prev_bus = {lcd_rs, lcd_data};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready_negedge(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.o_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, bus.o_ready, 1);
    endtask

    task automatic check_init();
        logic [7:0] exp_data [4];
        int         exp_rise [4];
        exp_data = '{8'h38, 8'h0C, 8'h01, 8'h06};
        exp_rise = '{51, 61, 71, 96};
        wait_ready_negedge("init_ready_timeout");
        chk("init_ready_cycle", cyc, 105);
        chk("init_pulse_count", pq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < pq.size()) begin
                chk($sformatf("init%0d_data", i), pq[i].data, exp_data[i]);
                chk($sformatf("init%0d_rs", i), pq[i].rs, 0);
                chk($sformatf("init%0d_width", i), pq[i].width, 3);
                chk($sformatf("init%0d_rise", i), pq[i].rise, exp_rise[i]);
                chk($sformatf("init%0d_setup", i), pq[i].setup_ok, 1);
            end
        end
    endtask

    // Single-byte write: returns the number of edges from accept until o_ready is high again.
    task automatic xfer(input logic rs, input logic [7:0] data, output int lat);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_rs    = rs;
        bus.i_data  = data;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_rs    = ~rs;
        bus.i_data  = ~data;
        chk("ready_drop", bus.o_ready, 0);
        chk("busy_rise", bus.o_busy, 1);
        lat = 0;
        while (!bus.o_ready && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat;
        int n;
        vecs = '{
            '{1'b1, 8'h41, 10}, '{1'b0, 8'h01, 25}, '{1'b1, 8'h01, 10},
            '{1'b0, 8'h02, 25}, '{1'b0, 8'h03, 25}, '{1'b0, 8'h04, 10},
            '{1'b0, 8'h00, 10}, '{1'b1, 8'hFF, 10}, '{1'b0, 8'h38, 10}
        };
        bus.i_valid = 1'b0;
        bus.i_rs    = 1'b0;
        bus.i_data  = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_busy", bus.o_busy, 1);
        chk("rst_on", lcd_on, 0);
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_data", lcd_data, 8'h00);

        reset_n = 1'b1;
        pq.delete();
        @(posedge clk);
        #1;
        chk("pwr_on_first_cycle", lcd_on, 1);
        chk("pwr_en_low", lcd_en, 0);
        check_init();

        for (int i = 0; i < 9; i++) begin
            pq.delete();
            xfer(vecs[i].rs, vecs[i].data, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_pulses", i), pq.size(), 1);
            if (pq.size() == 1) begin
                chk($sformatf("v%0d_data", i), pq[0].data, vecs[i].data);
                chk($sformatf("v%0d_rs", i), pq[0].rs, vecs[i].rs);
                chk($sformatf("v%0d_width", i), pq[0].width, 3);
                chk($sformatf("v%0d_setup", i), pq[0].setup_ok, 1);
                chk($sformatf("v%0d_stable", i), pq[0].stable, 1);
            end
            chk($sformatf("v%0d_rw", i), lcd_rw, 0);
        end

        // Backpressure: valid held across two accepts, byte switched at each accept.
        pq.delete();
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_rs    = 1'b1;
        bus.i_data  = 8'h48;
        @(posedge clk);
        #1;
        bus.i_data = 8'h49;
        n = 0;
        while (!bus.o_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_first_latency", n, 10);
        @(posedge clk);
        #1;
        chk("bp_second_accept", bus.o_ready, 0);
        bus.i_data  = 8'hEE;
        bus.i_valid = 1'b0;
        wait_ready_negedge("bp_ready_timeout");
        repeat (20) @(negedge clk);
        chk("bp_pulses", pq.size(), 2);
        if (pq.size() == 2) begin
            chk("bp_byte0", pq[0].data, 8'h48);
            chk("bp_byte1", pq[1].data, 8'h49);
            chk("bp_stable0", pq[0].stable, 1);
            chk("bp_stable1", pq[1].stable, 1);
        end

        // Reset while EN is high, then ignored valid during the rerun init.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_rs    = 1'b1;
        bus.i_data  = 8'h5A;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        n = 0;
        while (!lcd_en && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_en_seen", lcd_en, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_en", lcd_en, 0);
        chk("mid_rst_on", lcd_on, 0);
        chk("mid_rst_ready", bus.o_ready, 0);
        chk("mid_rst_data", lcd_data, 8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pq.delete();
        repeat (57) @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_rs    = 1'b1;
        bus.i_data  = 8'h99;
        @(negedge clk);
        bus.i_valid = 1'b0;
        check_init();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
HD44780-style character LCD driver that sits between the core's LCD output register and the LCD panel pins.
- The core side presents one command or data byte per transaction using a valid/ready handshake.
- The block generates the panel bus timing: setup, enable pulse, hold, then the command execution wait.
- After reset it runs the panel power-up wait and a fixed init sequence on its own.
- Software only needs to write bytes; it never bit-bangs enable.

Parameters:
T_SETUP, 2, cycles RS/DATA are stable before EN rises (>=1)
T_PULSE, 25, cycles EN is held high (>=1)
T_HOLD, 2, cycles RS/DATA are held after EN falls (>=1)
T_EXEC, 2000, execution wait after a normal command/data byte (>=1)
T_CLEAR, 82000, execution wait after clear (0x01) or home (0x02/0x03) with RS=0 (>=1)
T_POWERUP, 750000, wait after reset before the init sequence (>=1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
i_valid  in  1  request: byte on i_rs/i_data is valid
i_rs  in  1  0 = command, 1 = data
i_data  in  8  byte to send
o_ready  out  1  block can accept a byte this cycle
o_busy  out  1  init or a transfer is in progress (equals ~o_ready)
o_lcd_on  out  1  panel power/backlight enable
o_lcd_en  out  1  panel EN
o_lcd_rs  out  1  panel RS
o_lcd_rw  out  1  panel RW, always 0 (write only)
o_lcd_data  out  8  panel DB7..DB0

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values:
  - o_ready=0, o_busy=1.
  - o_lcd_on=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=8'h00.
  - State = PWR_WAIT, counter = 0, init index = 0.
- Registered outputs: every panel output comes straight from a flop, with no combinational path from inputs.
- States: PWR_WAIT, SETUP, PULSE, HOLD, EXEC, IDLE.
- PWR_WAIT:
  - o_lcd_on=1 from the first cycle after reset release.
  - Counts T_POWERUP cycles, then loads init byte 0 (RS=0) and goes to SETUP.
- Init sequence, RS=0: 0x38, 0x0C, 0x01, 0x06. It is held in a 4-entry constant table.
  - After each init byte's EXEC finishes, the index increments and the next byte goes to SETUP.
  - After index 3 the FSM enters IDLE.
- IDLE: o_ready=1.
  - Accept happens when i_valid && o_ready. The block latches i_rs/i_data and next state is SETUP.
  - o_ready is 0 from the cycle after the accept.
- SETUP: o_lcd_rs/o_lcd_data are driven with the latched byte, EN=0, for T_SETUP cycles. Then PULSE.
- PULSE: EN=1 for exactly T_PULSE cycles. Then HOLD.
- HOLD: EN=0, bus unchanged, for T_HOLD cycles. Then EXEC.
- EXEC: the wait is T_CLEAR if RS=0 and data is in {0x01, 0x02, 0x03}; otherwise it is T_EXEC. Then IDLE, or the next init byte.
- Latency: the accept cycle is followed by T_SETUP+T_PULSE+T_HOLD+wait cycles. o_ready returns high on the cycle after the last wait cycle.
- Bus retention: o_lcd_rs/o_lcd_data keep their last value in IDLE and change only on entering SETUP.
- Handshake rules:
  - i_valid while o_ready=0 is ignored, with no buffering; the initiator must hold i_valid until it is accepted.
  - Accepts are back-to-back: asserting i_valid in the first IDLE cycle is accepted immediately, with no bubble cycle.
  - i_data/i_rs changes after the accept have no effect on the transfer in progress.
- Counter:
  - A single down-counter, width $clog2 of the largest timing parameter plus 1.
  - Loaded with (N-1) on entering each timed state; the state exits when the counter reaches 0.
  - Never wraps.
- Reset mid-operation: outputs go to their reset values immediately (EN drops asynchronously). The full power-up wait and init sequence rerun after release.

Decomposition:
- Shared package lcd_pkg holds:
  - The state enum.
  - Init table constants (INIT_LEN=4, init bytes).
  - LCD command constants: CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_FUNC_8B2L=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY_INC=0x06.
- No sub-module is needed. The timing counter stays inline, since a separate timer module would only wrap one register.

Test Plan:
All scenarios use overrides T_SETUP=1, T_PULSE=3, T_HOLD=1, T_EXEC=5, T_CLEAR=20, T_POWERUP=50.
- Power-up:
  - Stimulus: release reset_n at t0.
  - Response: o_lcd_on=1 next cycle; first EN high after 50+1 cycles; four EN pulses each 3 cycles wide, carrying 0x38, 0x0C, 0x01, 0x06 with RS=0; the 0x01 pulse is followed by a 20-cycle wait; o_ready rises after the 0x06 EXEC.
- Data write:
  - Stimulus: in IDLE, i_valid=1, i_rs=1, i_data=0x41 for one cycle.
  - Response: o_ready drops next cycle; RS=1, DATA=0x41 are set 1 cycle before EN; EN high 3 cycles; o_ready returns exactly 1+3+1+5=10 cycles after the accept.
- Clear timing:
  - Stimulus: send RS=0, 0x01.
  - Response: o_ready returns 25 cycles after the accept. Sending RS=1, 0x01 instead returns it after 10 cycles.
- Backpressure:
  - Stimulus: hold i_valid=1 with bytes 0x48 then 0x49, switching the byte at each accept.
  - Response: exactly two transfers, no byte dropped or duplicated; i_data changes made mid-transfer never appear on o_lcd_data.
- Reset mid-PULSE:
  - Stimulus: assert reset_n=0 while EN=1.
  - Response: EN=0 and o_lcd_on=0 in the same cycle, without waiting for a clock edge; after release the full init sequence repeats.
- Ignored valid:
  - Stimulus: pulse i_valid for 1 cycle during init.
  - Response: no extra EN pulse; the init sequence is unchanged.
